// File: rtl/hazard_detection_unit.sv
// ID-stage stall/flush controller: stalls on hazards forwarding cannot cover, flushes IF/ID on
// taken branches and jumps. Define HAZARD_STATS_EN to enable saturating stall/flush counters.
module hazard_detection_unit #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ID_EX_MemRead,
   input  logic             ID_EX_RegWrite,
   input  logic [REG_W-1:0] ID_EX_RegisterRd,
   input  logic             EX_MEM_MemRead,
   input  logic [REG_W-1:0] EX_MEM_RegisterRd,
   input  logic [REG_W-1:0] IF_ID_RegisterRs,
   input  logic [REG_W-1:0] IF_ID_RegisterRt,
   input  logic             IF_ID_UsesRt,
   input  logic             beq,
   input  logic             bne,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             ID_EX_Bubble,
   output logic             IF_ID_Flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {StRun, StHold} state_t;

   state_t     state_q;
   logic [1:0] rem_q;

   logic is_branch, match_ex, match_mem;
   logic lu, ba, bl1, bl2, hazard, stall, flush;

   always_comb begin
      is_branch = beq | bne;
      match_ex  = (ID_EX_RegisterRd != '0) &&
                  ((ID_EX_RegisterRd == IF_ID_RegisterRs) ||
                   (IF_ID_UsesRt && (ID_EX_RegisterRd == IF_ID_RegisterRt)));
      match_mem = (EX_MEM_RegisterRd != '0) &&
                  ((EX_MEM_RegisterRd == IF_ID_RegisterRs) ||
                   (IF_ID_UsesRt && (EX_MEM_RegisterRd == IF_ID_RegisterRt)));
      lu     = ID_EX_MemRead & match_ex;
      ba     = is_branch & ID_EX_RegWrite & ~ID_EX_MemRead & match_ex;
      bl1    = is_branch & ID_EX_MemRead & match_ex;
      bl2    = is_branch & EX_MEM_MemRead & match_mem;
      hazard = (state_q == StRun) & (lu | ba | bl1 | bl2);
      // Reset gates the outputs so they take run values while rst_n is low.
      stall  = rst_n & ((state_q == StHold) | hazard);
      flush  = rst_n & ~stall & ((is_branch & branch_taken) | jump);
   end

   assign PCWrite      = ~stall;
   assign IF_ID_Write  = ~stall;
   assign ID_EX_Bubble = stall;
   assign IF_ID_Flush  = flush;

   // rem holds the stall cycles still owed after the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         rem_q   <= 2'd0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (hazard) begin
                  if (bl1) begin
                     rem_q   <= 2'd1;
                     state_q <= StHold;
                  end else begin
                     rem_q   <= 2'd0;
                  end
               end
            end
            StHold: begin
               rem_q <= rem_q - 2'd1;
               if (rem_q == 2'd1) state_q <= StRun;
            end
            default: begin
               state_q <= StRun;
               rem_q   <= 2'd0;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
         if (flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
